// File: rtl/fb_pkg.sv
// Shared frame-buffer constants for the scan-out, Sobel engine and write scheduler.
package fb_pkg;

    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned FB_W     = 80;
    localparam int unsigned FB_H     = 60;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;

    localparam logic [0:0] ARB     = 1'b0;
    localparam logic [0:0] CLR_RUN = 1'b1;

    localparam logic [DATA_W-1:0] CLEAR_COLOR = '0;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers who was served last.
module rr_arb2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_enable,
    output logic o_gnt0,
    output logic o_gnt1
);

    // 1 means requester 1 was served most recently, so requester 0 wins the next tie.
    logic r_last;

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_enable) begin
            if (i_valid0 && i_valid1) begin
                o_gnt0 = r_last;
                o_gnt1 = ~r_last;
            end else begin
                o_gnt0 = i_valid0;
                o_gnt1 = i_valid1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (o_gnt0) begin
            r_last <= 1'b0;
        end else if (o_gnt1) begin
            r_last <= 1'b1;
        end
    end

endmodule

// File: rtl/fb_write_sched.sv
// Frame-buffer write-port scheduler: round-robin between host and Sobel stream,
// plus a full-frame clear that is held off until the next vsync falling edge.
module fb_write_sched
    import fb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = fb_pkg::ADDR_W,
    parameter int unsigned       DATA_W      = fb_pkg::DATA_W,
    parameter int unsigned       DEPTH       = fb_pkg::FB_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = fb_pkg::CLEAR_COLOR
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vsync,
    input  logic              i_clear_req,
    input  logic              i_req0_valid,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_data,
    input  logic              i_req1_valid,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_clear_busy,
    output logic              o_clear_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic              r_pending;
    logic              r_vsync_q;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_clear_done;

    logic w_edge;
    logic w_clr_start;
    logic w_arb_en;
    logic w_gnt0;
    logic w_gnt1;

    // vsync is active low: the frame boundary is its falling edge.
    assign w_edge      = r_vsync_q & ~i_vsync;
    assign w_clr_start = (r_state == ARB) & (r_pending | i_clear_req) & w_edge;
    assign w_arb_en    = (r_state == ARB) & ~w_clr_start;

    rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid0 (i_req0_valid),
        .i_valid1 (i_req1_valid),
        .i_enable (w_arb_en),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ARB;
            r_pending    <= 1'b0;
            r_vsync_q    <= 1'b1;
            r_clr_cnt    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_vsync_q    <= i_vsync;
            r_wr_en      <= 1'b0;
            r_clear_done <= 1'b0;
            if (r_state == ARB) begin
                if (i_clear_req) begin
                    r_pending <= 1'b1;
                end
                if (w_clr_start) begin
                    r_state   <= CLR_RUN;
                    r_clr_cnt <= '0;
                end else if (w_gnt0) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= i_req0_addr;
                    r_wr_data <= i_req0_data;
                end else if (w_gnt1) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= i_req1_addr;
                    r_wr_data <= i_req1_data;
                end
            end else begin
                // Clear requests arriving mid-sweep are dropped on purpose.
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_clr_cnt;
                r_wr_data <= CLEAR_COLOR;
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == LAST_ADDR) begin
                    r_state      <= ARB;
                    r_pending    <= 1'b0;
                    r_clear_done <= 1'b1;
                end
            end
        end
    end

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_clear_busy = r_pending | (r_state == CLR_RUN);
    assign o_clear_done = r_clear_done;

endmodule

// File: tb/tb_fb_write_sched.sv
// Randomised bench for fb_write_sched against a cycle-level behavioural model.
module tb_fb_write_sched;
    import fb_pkg::*;

    localparam int unsigned AW  = fb_pkg::ADDR_W;
    localparam int unsigned DW  = fb_pkg::DATA_W;
    localparam int          DEP = int'(fb_pkg::FB_DEPTH);

    logic          clk = 1'b0;
    logic          rst, vsync, clear_req, v0, v1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          rdy0, rdy1, wr_en, busy, done;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int errors = 0;
    int checks = 0;

    // Model: sweep_left counts clear writes still to appear on the output.
    int            sweep_left;
    bit            pend, last1, vs_prev, g0, g1, start;
    bit            e_en, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    fb_write_sched dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_vsync      (vsync),
        .i_clear_req  (clear_req),
        .i_req0_valid (v0),
        .i_req0_addr  (a0),
        .i_req0_data  (d0),
        .i_req1_valid (v1),
        .i_req1_addr  (a1),
        .i_req1_data  (d1),
        .o_req0_ready (rdy0),
        .o_req1_ready (rdy1),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_clear_busy (busy),
        .o_clear_done (done)
    );

    always #5 clk = ~clk;

    task automatic predict();
        bit fall;
        fall  = vs_prev && !vsync;
        start = (sweep_left == 0) && (pend || clear_req) && fall;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst && sweep_left == 0 && !start) begin
            if (v0 && v1) begin
                g0 = last1;
                g1 = !last1;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
    endtask

    task automatic model_clock();
        e_en   = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            sweep_left = 0;
            pend       = 1'b0;
            last1      = 1'b1;
            vs_prev    = 1'b1;
            e_addr     = '0;
            e_data     = '0;
        end else begin
            if (sweep_left > 0) begin
                e_en   = 1'b1;
                e_addr = AW'(DEP - sweep_left);
                e_data = CLEAR_COLOR;
                sweep_left--;
                if (sweep_left == 0) begin
                    e_done = 1'b1;
                    pend   = 1'b0;
                end
            end else if (start) begin
                sweep_left = DEP;
                pend       = 1'b1;
            end else begin
                if (clear_req) pend = 1'b1;
                if (g0) begin e_en = 1'b1; e_addr = a0; e_data = d0; last1 = 1'b0; end
                if (g1) begin e_en = 1'b1; e_addr = a1; e_data = d1; last1 = 1'b1; end
            end
            vs_prev = vsync;
        end
    endtask

    task automatic advance();
        predict();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b1; clear_req = 1'b0; v0 = 1'b0; v1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        advance();
        advance();
        checks++;
        if ({rdy0, rdy1, wr_en, wr_addr, wr_data, busy, done} !== '0)
            begin errors++; $display("FAIL reset: got %b exp 0",
                {rdy0, rdy1, wr_en, wr_addr, wr_data, busy, done}); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        v0 = 1'b1; a0 = 13'h0010; d0 = 4'hA;
        #1;
        checks++;
        if ({rdy0, rdy1} !== 2'b10)
            begin errors++; $display("FAIL single_ready: got %b exp 10", {rdy0, rdy1}); end
        advance();
        v0 = 1'b0;
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 13'h0010, 4'hA})
            begin errors++; $display("FAIL single_write: got %b %h %h exp 1 0010 a",
                wr_en, wr_addr, wr_data); end
        #1;
        advance();
        checks++;
        if (wr_en !== 1'b0)
            begin errors++; $display("FAIL single_idle: got wr_en=%b exp 0", wr_en); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; a0 = AW'(16'h0100 + i); d0 = DW'(i);
            v1 = 1'b1; a1 = AW'(16'h0200 + i); d1 = DW'(i + 8);
            #1;
            checks++;
            if ({rdy0, rdy1} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL b2b_grant[%0d]: got %b", i, {rdy0, rdy1}); end
            advance();
            checks++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, e_addr, e_data})
                begin errors++; $display("FAIL b2b_write[%0d]: got %b %h %h exp 1 %h %h",
                    i, wr_en, wr_addr, wr_data, e_addr, e_data); end
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_random();
        vsync = 1'b1; clear_req = 1'b0;
        for (int c = 0; c < 300; c++) begin
            v0 = 1'($urandom); a0 = AW'($urandom); d0 = DW'($urandom);
            v1 = 1'($urandom); a1 = AW'($urandom); d1 = DW'($urandom);
            predict(); #1;
            checks++;
            if ({rdy0, rdy1} !== {g0, g1})
                begin errors++; $display("FAIL rand_ready[%0d]: got %b exp %b", c, {rdy0, rdy1}, {g0, g1}); end
            advance();
            checks++;
            if ({wr_en, busy, done} !== {e_en, pend || sweep_left > 0, e_done})
                begin errors++; $display("FAIL rand_status[%0d]: got %b exp %b", c, {wr_en, busy, done},
                    {e_en, pend || sweep_left > 0, e_done}); end
            if (e_en) begin
                checks++;
                if ({wr_addr, wr_data} !== {e_addr, e_data})
                    begin errors++; $display("FAIL rand_write[%0d]: got %h %h exp %h %h",
                        c, wr_addr, wr_data, e_addr, e_data); end
            end
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_clear_sweep();
        int dones = 0;
        int edge_cyc = -1;
        for (int c = 0; c < DEP + 140; c++) begin
            clear_req = (c == 0); vsync = (c < 100);
            v0 = 1'b0; v1 = 1'b1; a1 = AW'($urandom); d1 = DW'($urandom | 1);
            predict(); #1;
            if (start) edge_cyc = c;
            checks++;
            if ({rdy0, rdy1} !== {g0, g1})
                begin errors++; $display("FAIL sweep_ready[%0d]: got %b exp %b", c, {rdy0, rdy1}, {g0, g1}); end
            advance();
            checks++;
            if ({wr_en, busy, done} !== {e_en, pend || sweep_left > 0, e_done})
                begin errors++; $display("FAIL sweep_status[%0d]: got %b exp %b", c, {wr_en, busy, done},
                    {e_en, pend || sweep_left > 0, e_done}); end
            if (e_en) begin
                checks++;
                if ({wr_addr, wr_data} !== {e_addr, e_data})
                    begin errors++; $display("FAIL sweep_write[%0d]: got %h %h exp %h %h",
                        c, wr_addr, wr_data, e_addr, e_data); end
            end
            if (c == edge_cyc + 1 && edge_cyc >= 0) begin
                checks++;
                if ({wr_en, wr_addr, wr_data} !== {1'b1, {AW{1'b0}}, CLEAR_COLOR})
                    begin errors++; $display("FAIL sweep_first: got %b %h %h exp 1 0 0",
                        wr_en, wr_addr, wr_data); end
            end
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (wr_addr !== AW'(DEP - 1))
                    begin errors++; $display("FAIL sweep_done_addr: got %0d exp %0d", wr_addr, DEP - 1); end
            end
        end
        checks++;
        if (dones != 1)
            begin errors++; $display("FAIL sweep_done_count: got %0d exp 1", dones); end
        v1 = 1'b0; clear_req = 1'b0;
    endtask

    task automatic test_multi_req();
        int dones = 0;
        for (int c = 0; c < DEP + 60; c++) begin
            clear_req = (c == 2) || (c == 5) || (c == 1020); vsync = (c < 20);
            v0 = 1'($urandom); a0 = AW'($urandom); d0 = DW'($urandom); v1 = 1'b0;
            predict(); #1;
            checks++;
            if ({rdy0, rdy1} !== {g0, g1})
                begin errors++; $display("FAIL multi_ready[%0d]: got %b exp %b", c, {rdy0, rdy1}, {g0, g1}); end
            advance();
            checks++;
            if ({wr_en, busy, done} !== {e_en, pend || sweep_left > 0, e_done})
                begin errors++; $display("FAIL multi_status[%0d]: got %b exp %b", c, {wr_en, busy, done},
                    {e_en, pend || sweep_left > 0, e_done}); end
            if (e_en) begin
                checks++;
                if ({wr_addr, wr_data} !== {e_addr, e_data})
                    begin errors++; $display("FAIL multi_write[%0d]: got %h %h exp %h %h",
                        c, wr_addr, wr_data, e_addr, e_data); end
            end
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || busy !== 1'b0)
            begin errors++; $display("FAIL multi_once: got dones=%0d busy=%b exp 1 0", dones, busy); end
        v0 = 1'b0; clear_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        int busy_seen = 0;
        for (int c = 0; c < 2200 && !reached; c++) begin
            vsync = (c < 3); clear_req = (c == 3); v0 = 1'b1; a0 = AW'($urandom); d0 = DW'($urandom);
            predict(); #1;
            checks++;
            if ({rdy0, rdy1} !== {g0, g1})
                begin errors++; $display("FAIL rmid_ready[%0d]: got %b exp %b", c, {rdy0, rdy1}, {g0, g1}); end
            advance();
            checks++;
            if ({wr_en, wr_addr, busy} !== {e_en, e_addr, pend || sweep_left > 0})
                begin errors++; $display("FAIL rmid_write[%0d]: got %b %h %b exp %b %h %b", c, wr_en, wr_addr,
                    busy, e_en, e_addr, pend || sweep_left > 0); end
            if (e_en && sweep_left > 0 && e_addr == AW'(2000)) reached = 1'b1;
        end
        checks++;
        if (!reached)
            begin errors++; $display("FAIL rmid_reach: sweep never got to addr 2000"); end
        rst = 1'b1; v0 = 1'b0; clear_req = 1'b0;
        advance();
        checks++;
        if ({wr_en, busy, done, rdy0, rdy1} !== 5'b0)
            begin errors++; $display("FAIL rmid_after_rst: got %b exp 00000", {wr_en, busy, done, rdy0, rdy1}); end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            vsync = (c >= 5 && c < 10); v1 = 1'($urandom); a1 = AW'($urandom); d1 = DW'($urandom);
            predict(); #1;
            checks++;
            if ({rdy0, rdy1} !== {g0, g1})
                begin errors++; $display("FAIL rpost_ready[%0d]: got %b exp %b", c, {rdy0, rdy1}, {g0, g1}); end
            advance();
            if (busy === 1'b1) busy_seen++;
        end
        checks++;
        if (busy_seen != 0)
            begin errors++; $display("FAIL rpost_no_sweep: busy seen %0d cycles exp 0", busy_seen); end
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; clear_req = 1'b0; v0 = 1'b0; v1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_clear_sweep();
        test_multi_req();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
